// File: rtl/brick_health_tracker_pkg.sv
// Shared game constants for the brick tracker and the win checker.
package brick_health_tracker_pkg;
    localparam int BHT_NUM_BRICKS = 32;
    localparam int BHT_HEALTH_W   = 2;
    localparam int BHT_IDX_W      = $clog2(BHT_NUM_BRICKS);
    localparam int BHT_TOTAL_W    = 10;
endpackage

// File: rtl/brick_health_ram.sv
// Per-brick health store: one write port, one registered read port.
module brick_health_ram
    import brick_health_tracker_pkg::*;
#(
    parameter int DEPTH  = BHT_NUM_BRICKS,
    parameter int ADDR_W = BHT_IDX_W,
    parameter int DATA_W = BHT_HEALTH_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/brick_health_tracker.sv
// Brick health tracker: initialises every brick, then applies hits one at
// a time (accept, read, update) and reports health loss and destruction.
module brick_health_tracker
    import brick_health_tracker_pkg::*;
#(
    parameter int NUM_BRICKS = BHT_NUM_BRICKS,
    parameter int HEALTH_W   = BHT_HEALTH_W,
    localparam int IDX_W     = $clog2(NUM_BRICKS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [HEALTH_W-1:0]    init_health,
    input  logic                   hit_req,
    input  logic [IDX_W-1:0]       hit_index,
    output logic                   ready,
    output logic                   game_write,
    output logic [BHT_TOTAL_W-1:0] total_health,
    output logic                   brick_destroyed,
    output logic [IDX_W-1:0]       destroyed_index,
    output logic [NUM_BRICKS-1:0]  brick_alive
);
    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICKS - 1);

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_ready;
    logic                   r_gw;
    logic                   r_bd;
    logic [IDX_W-1:0]       r_didx;
    logic [BHT_TOTAL_W-1:0] r_total;
    logic [NUM_BRICKS-1:0]  r_alive;

    logic                   w_we;
    logic [IDX_W-1:0]       w_waddr;
    logic [HEALTH_W-1:0]    w_wdata;
    logic [HEALTH_W-1:0]    w_rd;
    logic [HEALTH_W-1:0]    w_dec;
    logic                   w_live;

    assign w_live = (w_rd != '0);
    assign w_dec  = w_rd - HEALTH_W'(1);

    // Dead bricks are never written, so health cannot wrap below zero.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = init_health;
        if (resetn && r_state == S_INIT) begin
            w_we = 1'b1;
        end else if (resetn && r_state == S_UPDATE && w_live) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = w_dec;
        end
    end

    brick_health_ram #(
        .DEPTH  (NUM_BRICKS),
        .ADDR_W (IDX_W),
        .DATA_W (HEALTH_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_gw    <= 1'b0;
            r_bd    <= 1'b0;
            r_didx  <= '0;
            r_total <= '0;
            r_alive <= '0;
        end else begin
            r_gw <= 1'b0;
            r_bd <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_total <= r_total + BHT_TOTAL_W'(init_health);
                    r_alive[r_cnt] <= (init_health != '0);
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (hit_req) begin
                        r_idx   <= hit_index;
                        r_state <= S_READ;
                        r_ready <= 1'b0;
                    end
                end
                S_READ: begin
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    if (w_live) begin
                        r_gw <= 1'b1;
                        r_alive[r_idx] <= (w_dec != '0);
                        if (w_dec == '0) begin
                            r_bd   <= 1'b1;
                            r_didx <= r_idx;
                        end
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign ready           = r_ready;
    assign game_write      = r_gw;
    assign brick_destroyed = r_bd;
    assign destroyed_index = r_didx;
    assign total_health    = r_total;
    assign brick_alive     = r_alive;
endmodule

// File: tb/tb_brick_health_tracker.sv
// Directed scenario bench for brick_health_tracker.
module tb_brick_health_tracker;
    localparam int NB = 32;
    localparam int HW = 2;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [HW-1:0] init_health = '0;
    logic          hit_req = 1'b0;
    logic [IW-1:0] hit_index = '0;
    logic          ready;
    logic          game_write;
    logic [9:0]    total_health;
    logic          brick_destroyed;
    logic [IW-1:0] destroyed_index;
    logic [NB-1:0] brick_alive;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brick_health_tracker #(
        .NUM_BRICKS (NB),
        .HEALTH_W   (HW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .init_health     (init_health),
        .hit_req         (hit_req),
        .hit_index       (hit_index),
        .ready           (ready),
        .game_write      (game_write),
        .total_health    (total_health),
        .brick_destroyed (brick_destroyed),
        .destroyed_index (destroyed_index),
        .brick_alive     (brick_alive)
    );

    task automatic do_reset(input logic [HW-1:0] ih, output int n);
        @(posedge clk); #1;
        resetn = 1'b0;
        hit_req = 1'b0;
        init_health = ih;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        init_health = 2'd2;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, game_write, brick_destroyed} !== 3'b000) begin
            failures++;
            $display("FAIL rst_ctl got=%b exp=000",
                     {ready, game_write, brick_destroyed});
        end
        checks++;
        if (total_health !== 10'd0 || destroyed_index !== '0) begin
            failures++;
            $display("FAIL rst_data tot=%0d didx=%0d exp=0",
                     total_health, destroyed_index);
        end
        checks++;
        if (brick_alive !== '0) begin
            failures++;
            $display("FAIL rst_alive got=%h exp=0", brick_alive);
        end
        resetn = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL init_len got=%0d exp=32", n);
        end
        checks++;
        if (total_health !== 10'd64) begin
            failures++;
            $display("FAIL init_total got=%0d exp=64", total_health);
        end
        checks++;
        if (brick_alive !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL init_alive got=%h exp=ffffffff", brick_alive);
        end
    endtask

    task automatic test_double_hit();
        for (int k = 0; k < 2; k++) begin
            hit_req = 1'b1;
            hit_index = 5'd5;
            @(posedge clk); #1;
            hit_req = 1'b0;
            checks++;
            if (ready !== 1'b0 || game_write !== 1'b0) begin
                failures++;
                $display("FAIL hit%0d_e0 rdy=%b gw=%b exp=0,0",
                         k, ready, game_write);
            end
            @(posedge clk); #1;
            checks++;
            if (game_write !== 1'b0) begin
                failures++;
                $display("FAIL hit%0d_e1 gw=%b exp=0", k, game_write);
            end
            @(posedge clk); #1;
            checks++;
            if (game_write !== 1'b1 || ready !== 1'b1) begin
                failures++;
                $display("FAIL hit%0d_e2 gw=%b rdy=%b exp=1,1",
                         k, game_write, ready);
            end
            checks++;
            if (brick_destroyed !== (k == 1)) begin
                failures++;
                $display("FAIL hit%0d_bd got=%b exp=%b",
                         k, brick_destroyed, k == 1);
            end
            if (k == 1) begin
                checks++;
                if (destroyed_index !== 5'd5) begin
                    failures++;
                    $display("FAIL didx got=%0d exp=5", destroyed_index);
                end
            end
        end
        checks++;
        if (brick_alive !== 32'hFFFF_FFDF) begin
            failures++;
            $display("FAIL alive5 got=%h exp=ffffffdf", brick_alive);
        end
    endtask

    task automatic test_dead_hit();
        int pulses = 0;
        hit_req = 1'b1;
        hit_index = 5'd5;
        @(posedge clk); #1;
        hit_req = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL dead_busy rdy=%b exp=0", ready);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            pulses += int'(game_write) + int'(brick_destroyed);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL dead_pulse got=%0d exp=0", pulses);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL dead_ready got=%b exp=1", ready);
        end
    endtask

    task automatic test_held();
        int n;
        int cnt = 0;
        int at[3] = '{0, 0, 0};
        logic prev = 1'b0;
        int dbl = 0;
        do_reset(2'd3, n);
        checks++;
        if (n != 32 || total_health !== 10'd96) begin
            failures++;
            $display("FAIL held_init n=%0d tot=%0d exp=32,96",
                     n, total_health);
        end
        hit_req = 1'b1;
        hit_index = 5'd7;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (game_write === 1'b1) begin
                if (cnt < 3) at[cnt] = c;
                cnt++;
            end
            if (prev && game_write) dbl++;
            prev = game_write;
        end
        hit_req = 1'b0;
        checks++;
        if (cnt != 3) begin
            failures++;
            $display("FAIL held_count got=%0d exp=3", cnt);
        end
        checks++;
        if (at[0] != 3 || at[1] != 6 || at[2] != 9) begin
            failures++;
            $display("FAIL held_times got=%0d,%0d,%0d exp=3,6,9",
                     at[0], at[1], at[2]);
        end
        checks++;
        if (dbl != 0 || brick_alive[7] !== 1'b0) begin
            failures++;
            $display("FAIL held_end dbl=%0d alive7=%b exp=0,0",
                     dbl, brick_alive[7]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses = 0;
        do_reset(2'd2, n);
        hit_req = 1'b1;
        hit_index = 5'd3;
        @(posedge clk); #1;
        hit_req = 1'b0;
        resetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            pulses += int'(game_write) + int'(brick_destroyed);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL mid_pulse got=%0d exp=0", pulses);
        end
        checks++;
        if (ready !== 1'b0 || total_health !== 10'd0 ||
            brick_alive !== '0) begin
            failures++;
            $display("FAIL mid_zero rdy=%b tot=%0d alive=%h exp=0",
                     ready, total_health, brick_alive);
        end
        resetn = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 32 || brick_alive !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mid_replay n=%0d alive=%h exp=32,ffffffff",
                     n, brick_alive);
        end
        hit_req = 1'b1;
        hit_index = 5'd3;
        @(posedge clk); #1;
        hit_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (game_write !== 1'b1 || brick_destroyed !== 1'b0) begin
            failures++;
            $display("FAIL mid_restored gw=%b bd=%b exp=1,0",
                     game_write, brick_destroyed);
        end
    endtask

    task automatic test_zero_init();
        int n;
        int pulses = 0;
        do_reset(2'd0, n);
        checks++;
        if (n != 32 || total_health !== 10'd0 || brick_alive !== '0) begin
            failures++;
            $display("FAIL zero_init n=%0d tot=%0d alive=%h exp=32,0,0",
                     n, total_health, brick_alive);
        end
        hit_req = 1'b1;
        hit_index = 5'd0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            pulses += int'(game_write) + int'(brick_destroyed);
        end
        hit_req = 1'b0;
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL zero_hit got=%0d exp=0", pulses);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_all_bricks();
        int n;
        int gw = 0;
        int bd = 0;
        int health_counter;
        do_reset(2'd1, n);
        health_counter = int'(total_health);
        checks++;
        if (health_counter != 32) begin
            failures++;
            $display("FAIL all_total got=%0d exp=32", health_counter);
        end
        for (int i = 0; i < 33; i++) begin
            hit_req = 1'b1;
            hit_index = IW'(i % 32);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                hit_req = 1'b0;
                if (game_write === 1'b1) begin
                    gw++;
                    health_counter--;
                end
                if (brick_destroyed === 1'b1) bd++;
            end
        end
        checks++;
        if (gw != 32 || bd != 32) begin
            failures++;
            $display("FAIL all_pulses gw=%0d bd=%0d exp=32,32", gw, bd);
        end
        checks++;
        if (health_counter != 0 || brick_alive !== '0) begin
            failures++;
            $display("FAIL all_end cnt=%0d alive=%h exp=0,0",
                     health_counter, brick_alive);
        end
    endtask

    initial begin
        test_reset();
        test_double_hit();
        test_dead_hit();
        test_held();
        test_reset_mid();
        test_zero_init();
        test_all_bricks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brick_health_tracker.md
BRICK_HEALTH_TRACKER -- requirements
Module: brick_health_tracker

Interface
REQ-001 The block SHALL have parameter NUM_BRICKS, default 32, giving the number of bricks tracked; it SHALL be a power of two, max 64.
REQ-002 The block SHALL have parameter HEALTH_W, default 2, giving the per-brick health width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port resetn, input, 1 bit: the reset; it SHALL be synchronous and active-low.
REQ-005 Port init_health, input, HEALTH_W bits: starting health for every brick, sampled during INIT.
REQ-006 Port hit_req, input, 1 bit: the ball collision logic requests a hit on a brick.
REQ-007 Port hit_index, input, log2(NUM_BRICKS) bits: the index of the brick hit, valid with hit_req.
REQ-008 Port ready, output, 1 bit: registered; high only in IDLE.
REQ-009 Port game_write, output, 1 bit: one-cycle pulse per health point removed; drives the win checker's game_write.
REQ-010 Port total_health, output, 10 bits: sum of the initial health of all bricks; drives the win checker's total_health.
REQ-011 Port brick_destroyed, output, 1 bit: one-cycle pulse when a brick's health reaches 0.
REQ-012 Port destroyed_index, output, log2(NUM_BRICKS) bits: index of the destroyed brick, valid with brick_destroyed.
REQ-013 Port brick_alive, output, NUM_BRICKS bits: bit i SHALL be high iff brick i health is nonzero; used by the renderer.

Function
REQ-014 The FSM SHALL have states INIT, IDLE, READ and UPDATE.
REQ-015 INIT SHALL write init_health to one brick per cycle, index 0 to NUM_BRICKS-1, accumulating total_health, then go to IDLE; it SHALL last exactly NUM_BRICKS cycles.
REQ-016 total_health SHALL be zero-extended, unsigned, and equal NUM_BRICKS*init_health; it SHALL be stable from the first IDLE cycle until the next reset.
REQ-017 A hit SHALL be accepted on a rising edge where ready=1 and hit_req=1; hit_index SHALL be captured on that edge, and the FSM SHALL go to READ.
REQ-018 hit_req while ready=0 SHALL be ignored and SHALL NOT be queued; the requester SHALL hold hit_req until it sees ready.
REQ-019 READ SHALL fetch the captured brick's health and go to UPDATE.
REQ-020 UPDATE SHALL behave as follows, then return to IDLE:
- If health is nonzero: write health-1 and pulse game_write exactly 2 cycles after the acceptance edge.
- If health-1 is 0: also pulse brick_destroyed and drive destroyed_index.
REQ-021 A hit on a brick with health 0 SHALL leave health unchanged and SHALL produce no pulses.
REQ-022 At most one game_write pulse SHALL be produced per accepted hit; game_write SHALL never be high in two consecutive cycles.
REQ-023 Throughput SHALL be one hit per 3 cycles.
REQ-024 If init_health is 0: total_health SHALL be 0, brick_alive SHALL be all zero, and every hit SHALL be a no-op.
REQ-025 Health SHALL never wrap below 0.

Reset
REQ-026 While resetn=0, the block SHALL set:
- FSM state to INIT, INIT counter to 0;
- ready, game_write and brick_destroyed to 0;
- destroyed_index, total_health and brick_alive to 0.
REQ-027 Reset asserted mid-operation (READ/UPDATE) SHALL abort the hit with no pulse; INIT SHALL restart from index 0 on the first cycle with resetn=1.
REQ-028 Reset SHALL take priority over every other input.

Structure
REQ-029 The health store SHALL be a register array in a sub-module, brick_health_ram, with a 1-read/1-write port, synchronous write and registered read.
REQ-030 The shared game constants header SHALL hold NUM_BRICKS, HEALTH_W, the index width and the 10-bit health width shared with the win checker.
REQ-031 The FSM state encoding SHALL be local to this module.

Verification
REQ-032 Scenario: init_health=2, release reset -> ready rises after 32 cycles; total_health=64; brick_alive=all ones.
REQ-033 Scenario: hit index 5 twice -> two game_write pulses, each 2 cycles after acceptance; brick_destroyed with destroyed_index=5 on the second; brick_alive[5]=0.
REQ-034 Scenario: third hit on index 5 -> no game_write, no brick_destroyed; ready returns after 3 cycles.
REQ-035 Scenario: hit_req held high continuously on index 7 with init_health=3 -> exactly 3 game_write pulses, spaced 3 cycles apart; no further pulses.
REQ-036 Scenario: resetn=0 in the READ cycle of a hit -> no pulse; all outputs 0; INIT replays; the brick's health is restored.
REQ-037 Scenario: init_health=1, hit all 32 bricks, connected to the win checker -> 32 game_write pulses; the win checker asserts its win output on the next game_write after health_counter reaches 0.
